// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, forwarding encodings and slot helpers for hazard_unit
package hazard_pkg;

    localparam int SLOT_AW = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic [SLOT_AW-1:0] rs1;
        logic [SLOT_AW-1:0] rs2;
        logic [SLOT_AW-1:0] rd;
        logic               regwrite;
        logic               isload;
    } shadow_slot_t;

    localparam int SLOT_W = $bits(shadow_slot_t);
    localparam shadow_slot_t SLOT_BUBBLE = '0;

    // x0 writes are architecturally discarded, so they never count as live
    function automatic logic slot_live(input shadow_slot_t s);
        return s.regwrite && (s.rd != '0);
    endfunction

    function automatic logic slot_hits(input shadow_slot_t s,
                                       input logic [SLOT_AW-1:0] a,
                                       input logic [SLOT_AW-1:0] b);
        return slot_live(s) && ((s.rd == a) || (s.rd == b));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [SLOT_AW-1:0] src,
                                           input shadow_slot_t m,
                                           input shadow_slot_t w);
        if (slot_live(m) && (m.rd == src))
            return FWD_M;
        else if (slot_live(w) && (w.rd == src))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one shadow pipeline slot with async clear and sync bubble load
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic [SLOT_W-1:0] d,
    output logic [SLOT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= SLOT_BUBBLE;
        else if (bubble)
            q <= SLOT_BUBBLE;
        else
            q <= d;
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RV32I stall/flush/forward controller; FORWARDING_EN selects bypass vs. full interlock
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              ResultSrcD,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    shadow_slot_t dec;
    shadow_slot_t slot_e;
    shadow_slot_t slot_m;
    shadow_slot_t slot_w;

    logic       hazard;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       unused_slot_bits;

    assign dec = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, regwrite: RegWriteD, isload: ResultSrcD};

    hazard_stage_reg u_slot_e (
        .clk    (clk),
        .rst    (rst),
        .bubble (FlushE),
        .d      (dec),
        .q      (slot_e)
    );

    hazard_stage_reg u_slot_m (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .d      (slot_e),
        .q      (slot_m)
    );

    hazard_stage_reg u_slot_w (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .d      (slot_m),
        .q      (slot_w)
    );

    always_comb begin
        hazard = 1'b0;
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
`ifdef FORWARDING_EN
        hazard = slot_e.isload && slot_hits(slot_e, Rs1D, Rs2D);
        fwd_a  = fwd_sel(slot_e.rs1, slot_m, slot_w);
        fwd_b  = fwd_sel(slot_e.rs2, slot_m, slot_w);
`else
        // No bypass and no register-file write-through: wait until the writer retires from W
        hazard = slot_hits(slot_e, Rs1D, Rs2D)
              || slot_hits(slot_m, Rs1D, Rs2D)
              || slot_hits(slot_w, Rs1D, Rs2D);
`endif
    end

    // A taken branch squashes the Decode instruction, so its stall is moot
    assign stall     = rst && hazard && !PCSrcE;
    assign StallF    = stall;
    assign StallD    = stall;
    assign FlushD    = rst && PCSrcE;
    assign FlushE    = rst && (PCSrcE || stall);
    assign ForwardAE = rst ? fwd_a : FWD_RF;
    assign ForwardBE = rst ? fwd_b : FWD_RF;

    assign unused_slot_bits = ^{slot_w.rs1, slot_w.rs2, slot_w.isload,
                                slot_e.rs1, slot_e.rs2, slot_m.isload};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallD && (StallCount != CNT_MAX))
                StallCount <= StallCount + 1'b1;
            if (FlushD && (FlushCount != CNT_MAX))
                FlushCount <= FlushCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit, directed vectors for either FORWARDING_EN build
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  Rs1D = '0;
    logic [4:0]  Rs2D = '0;
    logic [4:0]  RdD = '0;
    logic        RegWriteD = 1'b0;
    logic        ResultSrcD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .PCSrcE     (PCSrcE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   sc_m = 0;
    int   fc_m = 0;

    task automatic chk(input string nm, input int id, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, id, act, req);
        end
    endtask

    // ctl = {StallF, StallD, FlushD, FlushE}
    task automatic vec(input int id, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic pc,
                       input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; Rs1D = rs1; Rs2D = rs2; RdD = rd;
        RegWriteD = rw; ResultSrcD = ld; PCSrcE = pc;
        if (!r) begin
            sc_m = 0;
            fc_m = 0;
        end
        e.id = id; e.ctl = ctl; e.fa = fa; e.fb = fb; e.sc = sc_m; e.fc = fc_m;
        exp_q.push_back(e);
        if (ctl[2]) sc_m++;
        if (ctl[1]) fc_m++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("StallF", e.id, int'(StallF), int'(e.ctl[3]));
            chk("StallD", e.id, int'(StallD), int'(e.ctl[2]));
            chk("FlushD", e.id, int'(FlushD), int'(e.ctl[1]));
            chk("FlushE", e.id, int'(FlushE), int'(e.ctl[0]));
            chk("ForwardAE", e.id, int'(ForwardAE), int'(e.fa));
            chk("ForwardBE", e.id, int'(ForwardBE), int'(e.fb));
            chk("StallCount", e.id, int'(StallCount), e.sc);
            chk("FlushCount", e.id, int'(FlushCount), e.fc);
        end
    end

    initial begin
        //   id rst rs1 rs2 rd rw ld pc  ctl      fa     fb
        vec( 0, 0,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
`ifdef FORWARDING_EN
        vec( 1, 1,  1,  2,  5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec( 2, 1,  5,  3,  6, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec( 3, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b10, 2'b00);
        vec( 4, 1,  1,  2,  5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec( 5, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec( 6, 1,  4,  5,  7, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec( 7, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b01);
        vec( 8, 1,  1,  0,  5, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        vec( 9, 1,  5,  5,  6, 1, 0, 0, 4'b1101, 2'b00, 2'b00);
        vec(10, 1,  5,  5,  6, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(11, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b01, 2'b01);
        vec(12, 1,  1,  0,  8, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        vec(13, 1,  8,  2,  9, 1, 0, 1, 4'b0011, 2'b00, 2'b00);
        vec(14, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(15, 1,  1,  0,  0, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        vec(16, 1,  0,  0,  1, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(17, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(18, 1,  1,  0,  5, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        vec(19, 1,  5,  5,  6, 1, 0, 0, 4'b1101, 2'b01, 2'b00);
        vec(20, 0,  5,  5,  6, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(21, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
`else
        vec( 1, 1,  1,  2,  5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec( 2, 1,  5,  3,  6, 1, 0, 0, 4'b1101, 2'b00, 2'b00);
        vec( 3, 1,  5,  3,  6, 1, 0, 0, 4'b1101, 2'b00, 2'b00);
        vec( 4, 1,  5,  3,  6, 1, 0, 0, 4'b1101, 2'b00, 2'b00);
        vec( 5, 1,  5,  3,  6, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec( 6, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec( 7, 1,  1,  0,  8, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        vec( 8, 1,  8,  2,  9, 1, 0, 1, 4'b0011, 2'b00, 2'b00);
        vec( 9, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(10, 1,  1,  0,  0, 1, 1, 0, 4'b0000, 2'b00, 2'b00);
        vec(11, 1,  0,  0,  1, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(12, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(13, 1,  3,  2,  5, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(14, 1,  5,  3,  6, 1, 0, 0, 4'b1101, 2'b00, 2'b00);
        vec(15, 0,  5,  3,  6, 1, 0, 0, 4'b0000, 2'b00, 2'b00);
        vec(16, 1,  0,  0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00);
`endif
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
